// File: rtl/trng_api_master.sv
// rtl/trng_api_master.sv - framed byte-stream initiator for the TRNG register API (optional TRNG_API_MASTER_TIMEOUT_EN)
module trng_api_master #(
    parameter logic [7:0]  SOC            = 8'h55,
    parameter logic [7:0]  EOC            = 8'haa,
    parameter logic [7:0]  SOR            = 8'haa,
    parameter logic [7:0]  EOR            = 8'h55,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_syn,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic        tx_syn,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    output logic        cs,
    output logic        we,
    output logic [7:0]  address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        error,
    output logic        busy
);

    typedef enum logic [2:0] {
        RX_SOC, RX_CMD, RX_ADDR, RX_DATA, RX_EOC, ACCESS, TX_RESP
    } state_t;

    state_t      state, state_next;
    logic        rx_state;
    logic        byte_take;
    logic        is_write;
    logic        cmd_valid;
    logic [1:0]  data_cnt;
    logic [7:0]  resp_buf [8];
    logic [2:0]  resp_last;
    logic [2:0]  tx_idx;
    logic        tx_done;
    logic        timeout;

    assign rx_state  = (state != ACCESS) && (state != TX_RESP);
    assign byte_take = rx_syn && !rx_ack && rx_state;
    assign cmd_valid = (rx_data == 8'h10) || (rx_data == 8'h11);
    assign tx_done   = tx_syn && tx_ack && (tx_idx == resp_last);

    assign cs   = (state == ACCESS);
    assign we   = cs && is_write;
    assign busy = (state != RX_SOC);

`ifdef TRNG_API_MASTER_TIMEOUT_EN
    logic [31:0] gap_cnt;

    // Gap counter only runs while a frame is partially received.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= 32'd0;
        end else if (byte_take || !rx_state || state == RX_SOC) begin
            gap_cnt <= 32'd0;
        end else if (!timeout) begin
            gap_cnt <= gap_cnt + 32'd1;
        end
    end

    assign timeout = (gap_cnt == TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RX_SOC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_SOC:  if (byte_take && rx_data == SOC) state_next = RX_CMD;
            RX_CMD:  if (byte_take) state_next = cmd_valid ? RX_ADDR : TX_RESP;
            RX_ADDR: if (byte_take) state_next = is_write ? RX_DATA : RX_EOC;
            RX_DATA: if (byte_take && data_cnt == 2'd3) state_next = RX_EOC;
            RX_EOC:  if (byte_take) state_next = (rx_data == EOC) ? ACCESS : RX_SOC;
            ACCESS:  state_next = TX_RESP;
            TX_RESP: if (tx_done) state_next = RX_SOC;
            default: state_next = RX_SOC;
        endcase
        if (timeout && !byte_take) begin
            state_next = RX_SOC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ack     <= 1'b0;
            tx_syn     <= 1'b0;
            tx_data    <= 8'h00;
            is_write   <= 1'b0;
            data_cnt   <= 2'd0;
            address    <= 8'h00;
            write_data <= 32'h0;
            resp_last  <= 3'd0;
            tx_idx     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                resp_buf[i] <= 8'h00;
            end
        end else begin
            if (byte_take) begin
                rx_ack <= 1'b1;
            end else if (!rx_syn) begin
                rx_ack <= 1'b0;
            end

            if (byte_take) begin
                case (state)
                    RX_CMD: begin
                        is_write <= (rx_data == 8'h11);
                        if (!cmd_valid) begin
                            resp_buf[0] <= SOR;
                            resp_buf[1] <= 8'hfe;
                            resp_buf[2] <= rx_data;
                            resp_buf[3] <= EOR;
                            resp_last   <= 3'd3;
                            tx_idx      <= 3'd0;
                        end
                    end
                    RX_ADDR: begin
                        address  <= rx_data;
                        data_cnt <= 2'd0;
                    end
                    RX_DATA: begin
                        write_data <= {write_data[23:0], rx_data};
                        data_cnt   <= data_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end

            // The responder's result is captured as ACCESS ends; SOR goes out immediately.
            if (state == ACCESS) begin
                resp_buf[0] <= SOR;
                resp_buf[2] <= address;
                tx_idx      <= 3'd0;
                tx_syn      <= 1'b1;
                tx_data     <= SOR;
                if (error || is_write) begin
                    resp_buf[1] <= error ? 8'hfd : 8'h7e;
                    resp_buf[3] <= EOR;
                    resp_last   <= 3'd3;
                end else begin
                    resp_buf[1] <= 8'h7f;
                    resp_buf[3] <= read_data[31:24];
                    resp_buf[4] <= read_data[23:16];
                    resp_buf[5] <= read_data[15:8];
                    resp_buf[6] <= read_data[7:0];
                    resp_buf[7] <= EOR;
                    resp_last   <= 3'd7;
                end
            end

            if (state == TX_RESP) begin
                if (tx_syn && tx_ack) begin
                    tx_syn <= 1'b0;
                    tx_idx <= tx_idx + 3'd1;
                end else if (!tx_syn && !tx_ack) begin
                    tx_syn  <= 1'b1;
                    tx_data <= resp_buf[tx_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_api_master.sv
// tb/tb_trng_api_master.sv - directed self-checking bench for trng_api_master
`timescale 1ns/1ps
module tb_trng_api_master;

    logic        clk;
    logic        reset_n;
    logic        rx_syn;
    logic [7:0]  rx_data;
    logic        rx_ack;
    logic        tx_syn;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          cs_count = 0;
    int          cs_cyc = 0;
    int          tx_rise = 0;
    int          ack_rise = 0;
    logic        cs_we = 1'b0;
    logic [7:0]  cs_addr = 8'h00;
    logic [31:0] cs_wdata = 32'h0;
    logic        tx_syn_d = 1'b0;
    logic        rx_ack_d = 1'b0;
    int          cs_base;

    trng_api_master #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_syn     (rx_syn),
        .rx_data    (rx_data),
        .rx_ack     (rx_ack),
        .tx_syn     (tx_syn),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .error      (error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs === 1'b1) begin
            cs_count = cs_count + 1;
            cs_cyc   = cyc;
            cs_we    = we;
            cs_addr  = address;
            cs_wdata = write_data;
        end
        if (tx_syn === 1'b1 && tx_syn_d !== 1'b1) tx_rise = cyc;
        if (rx_ack === 1'b1 && rx_ack_d !== 1'b1) ack_rise = cyc;
        tx_syn_d = tx_syn;
        rx_ack_d = rx_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data = b;
        rx_syn  = 1'b1;
        n = 0;
        while (rx_ack !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (rx_ack !== 1'b1) begin errors++; $error("FAIL rx_ack_high observed=%0h expected=%0h", rx_ack, 1'b1); end
        rx_syn = 1'b0;
        n = 0;
        while (rx_ack !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (rx_ack !== 1'b0) begin errors++; $error("FAIL rx_ack_low observed=%0h expected=%0h", rx_ack, 1'b0); end
        tick();
    endtask

    task automatic get_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (tx_syn !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (tx_syn !== 1'b1) begin errors++; $error("FAIL tx_syn_high observed=%0h expected=%0h", tx_syn, 1'b1); end
        b = tx_data;
        tx_ack = 1'b1;
        n = 0;
        while (tx_syn !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL tx_syn_low observed=%0h expected=%0h", tx_syn, 1'b0); end
        tx_ack = 1'b0;
        tick();
    endtask

    task automatic expect_resp(input int nbytes, input logic [63:0] exp, input string tag);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            get_byte(b);
            checks++;
            if (b !== exp[63-8*i -: 8]) begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, b, exp[63-8*i -: 8]); end
        end
        repeat (5) tick();
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL no_extra_tx observed=%0h expected=%0h", tx_syn, 1'b0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $error("FAIL idle_after_resp observed=%0h expected=%0h", busy, 1'b0); end
    endtask

    task automatic send_frame(input int nbytes, input logic [63:0] frame);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frame[63-8*i -: 8]);
        end
    endtask

    initial begin
        logic [7:0] b;
        reset_n   = 1'b0;
        rx_syn    = 1'b0;
        rx_data   = 8'h00;
        tx_ack    = 1'b0;
        read_data = 32'h0;
        error     = 1'b0;
        repeat (3) tick();
        checks++;
        if (rx_ack !== 1'b0) begin errors++; $error("FAIL rst_rx_ack observed=%0h expected=%0h", rx_ack, 1'b0); end
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL rst_tx_syn observed=%0h expected=%0h", tx_syn, 1'b0); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $error("FAIL rst_tx_data observed=%0h expected=%0h", tx_data, 8'h00); end
        checks++;
        if (cs !== 1'b0) begin errors++; $error("FAIL rst_cs observed=%0h expected=%0h", cs, 1'b0); end
        checks++;
        if (we !== 1'b0) begin errors++; $error("FAIL rst_we observed=%0h expected=%0h", we, 1'b0); end
        checks++;
        if (address !== 8'h00) begin errors++; $error("FAIL rst_address observed=%0h expected=%0h", address, 8'h00); end
        checks++;
        if (write_data !== 32'h0) begin errors++; $error("FAIL rst_write_data observed=%0h expected=%0h", write_data, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0h expected=%0h", busy, 1'b0); end
        reset_n = 1'b1;
        tick();

        read_data = 32'h73686132;
        cs_base = cs_count;
        send_frame(4, 64'h551000AA_00000000);
        checks++;
        if (cs_count - cs_base !== 1) begin errors++; $error("FAIL rd_cs_count observed=%0h expected=%0h", cs_count - cs_base, 1); end
        checks++;
        if (cs_we !== 1'b0) begin errors++; $error("FAIL rd_we observed=%0h expected=%0h", cs_we, 1'b0); end
        checks++;
        if (cs_addr !== 8'h00) begin errors++; $error("FAIL rd_addr observed=%0h expected=%0h", cs_addr, 8'h00); end
        checks++;
        if (cs_cyc !== ack_rise) begin errors++; $error("FAIL rd_cs_latency observed=%0h expected=%0h", cs_cyc, ack_rise); end
        checks++;
        if (tx_rise !== cs_cyc + 1) begin errors++; $error("FAIL rd_tx_latency observed=%0h expected=%0h", tx_rise, cs_cyc + 1); end
        expect_resp(8, 64'hAA7F0073_68613255, "rd_resp");

        cs_base = cs_count;
        send_frame(8, 64'h551120DE_ADBEEFAA);
        checks++;
        if (cs_count - cs_base !== 1) begin errors++; $error("FAIL wr_cs_count observed=%0h expected=%0h", cs_count - cs_base, 1); end
        checks++;
        if (cs_we !== 1'b1) begin errors++; $error("FAIL wr_we observed=%0h expected=%0h", cs_we, 1'b1); end
        checks++;
        if (cs_addr !== 8'h20) begin errors++; $error("FAIL wr_addr observed=%0h expected=%0h", cs_addr, 8'h20); end
        checks++;
        if (cs_wdata !== 32'hDEADBEEF) begin errors++; $error("FAIL wr_wdata observed=%0h expected=%0h", cs_wdata, 32'hDEADBEEF); end
        expect_resp(4, 64'hAA7E2055_00000000, "wr_resp");
        checks++;
        if (address !== 8'h20) begin errors++; $error("FAIL wr_addr_hold observed=%0h expected=%0h", address, 8'h20); end
        checks++;
        if (write_data !== 32'hDEADBEEF) begin errors++; $error("FAIL wr_wdata_hold observed=%0h expected=%0h", write_data, 32'hDEADBEEF); end
        checks++;
        if (cs !== 1'b0) begin errors++; $error("FAIL wr_cs_idle observed=%0h expected=%0h", cs, 1'b0); end

        error = 1'b1;
        cs_base = cs_count;
        send_frame(4, 64'h551005AA_00000000);
        checks++;
        if (cs_count - cs_base !== 1) begin errors++; $error("FAIL rderr_cs_count observed=%0h expected=%0h", cs_count - cs_base, 1); end
        expect_resp(4, 64'hAAFD0555_00000000, "rderr_resp");
        send_frame(8, 64'h55113011_223344AA);
        checks++;
        if (cs_count - cs_base !== 2) begin errors++; $error("FAIL wrerr_cs_count observed=%0h expected=%0h", cs_count - cs_base, 2); end
        checks++;
        if (cs_wdata !== 32'h11223344) begin errors++; $error("FAIL wrerr_wdata observed=%0h expected=%0h", cs_wdata, 32'h11223344); end
        expect_resp(4, 64'hAAFD3055_00000000, "wrerr_resp");
        error = 1'b0;

        cs_base = cs_count;
        send_frame(4, 64'h00135542_00000000);
        expect_resp(4, 64'hAAFE4255_00000000, "unk_resp");
        checks++;
        if (cs_count - cs_base !== 0) begin errors++; $error("FAIL unk_no_cs observed=%0h expected=%0h", cs_count - cs_base, 0); end

        send_frame(4, 64'h55100000_00000000);
        repeat (10) tick();
        checks++;
        if (cs_count - cs_base !== 0) begin errors++; $error("FAIL badeoc_no_cs observed=%0h expected=%0h", cs_count - cs_base, 0); end
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL badeoc_no_tx observed=%0h expected=%0h", tx_syn, 1'b0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $error("FAIL badeoc_idle observed=%0h expected=%0h", busy, 1'b0); end
        read_data = 32'h01020304;
        send_frame(4, 64'h551007AA_00000000);
        checks++;
        if (cs_count - cs_base !== 1) begin errors++; $error("FAIL after_badeoc_cs observed=%0h expected=%0h", cs_count - cs_base, 1); end
        expect_resp(8, 64'hAA7F0701_02030455, "after_badeoc_resp");

        send_frame(4, 64'h551007AA_00000000);
        for (int i = 0; i < 3; i++) get_byte(b);
        for (int i = 0; i < 40 && tx_syn !== 1'b1; i++) tick();
        checks++;
        if (tx_syn !== 1'b1) begin errors++; $error("FAIL midresp_tx_syn_pre observed=%0h expected=%0h", tx_syn, 1'b1); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL midresp_tx_syn observed=%0h expected=%0h", tx_syn, 1'b0); end
        checks++;
        if (cs !== 1'b0) begin errors++; $error("FAIL midresp_cs observed=%0h expected=%0h", cs, 1'b0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $error("FAIL midresp_busy observed=%0h expected=%0h", busy, 1'b0); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $error("FAIL midresp_tx_data observed=%0h expected=%0h", tx_data, 8'h00); end
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL midresp_no_tx observed=%0h expected=%0h", tx_syn, 1'b0); end

        send_frame(2, 64'h5510_0000_0000_0000);
        repeat (20) tick();
`ifdef TRNG_API_MASTER_TIMEOUT_EN
        checks++;
        if (busy !== 1'b0) begin errors++; $error("FAIL stall_timeout_busy observed=%0h expected=%0h", busy, 1'b0); end
`else
        checks++;
        if (busy !== 1'b1) begin errors++; $error("FAIL stall_wait_busy observed=%0h expected=%0h", busy, 1'b1); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`endif
        checks++;
        if (tx_syn !== 1'b0) begin errors++; $error("FAIL stall_no_tx observed=%0h expected=%0h", tx_syn, 1'b0); end
        read_data = 32'hCAFEF00D;
        cs_base = cs_count;
        send_frame(4, 64'h551009AA_00000000);
        checks++;
        if (cs_count - cs_base !== 1) begin errors++; $error("FAIL post_stall_cs observed=%0h expected=%0h", cs_count - cs_base, 1); end
        checks++;
        if (cs_addr !== 8'h09) begin errors++; $error("FAIL post_stall_addr observed=%0h expected=%0h", cs_addr, 8'h09); end
        expect_resp(8, 64'hAA7F09CA_FEF00D55, "post_stall_resp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
